sync_fifo_param: RTL

//   Parametrised single-clock synchronous FIFO. Successor to the fixed 8-bit FIFO between the

---
 rtl/sync_fifo_param.sv | 120 ++++++++++++
 1 files changed

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with fill count, programmable almost flags,
// sticky overflow/underflow errors and optional first-word-fall-through output.
module sync_fifo_param #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 4,
  parameter int AFULL_LVL  = 14,
  parameter int AEMPTY_LVL = 2,
  parameter int FWFT       = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              write,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read,
  output logic [DATA_W-1:0] data_out,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W+1)'(AFULL_LVL);
  localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W+1)'(AEMPTY_LVL);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  if ((AFULL_LVL < 1) || (AFULL_LVL > DEPTH)) begin : g_bad_afull
    $error("sync_fifo_param: AFULL_LVL out of range 1..DEPTH");
  end
  if ((AEMPTY_LVL < 0) || (AEMPTY_LVL >= DEPTH)) begin : g_bad_aempty
    $error("sync_fifo_param: AEMPTY_LVL out of range 0..DEPTH-1");
  end

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [DATA_W-1:0] dout_r;
  logic [ADDR_W:0]   count_nxt_s;
  logic              rd_acc_s;
  logic              wr_acc_s;
  logic              ovf_set_s;
  logic              unf_set_s;

  // Accept decisions, next fill count and error set conditions.
  always_comb begin
    rd_acc_s  = en & read & ~empty;
    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    wr_acc_s  = en & write & (~full | rd_acc_s);
    ovf_set_s = en & write & full & ~rd_acc_s;
    unf_set_s = en & read & empty;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_nxt_s = count + CNT_ONE;
      2'b01:   count_nxt_s = count - CNT_ONE;
      default: count_nxt_s = count;
    endcase
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r] <= data_in;
    end
  end

  // Pointers, count, flags, read data register and sticky errors.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      count        <= '0;
      dout_r       <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else if (en) begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
        dout_r   <= mem_r[rd_ptr_r];
      end
      count        <= count_nxt_s;
      empty        <= (count_nxt_s == '0);
      full         <= (count_nxt_s == DEPTH_C);
      almost_empty <= (count_nxt_s <= AEMPTY_C);
      almost_full  <= (count_nxt_s >= AFULL_C);
      // Set wins over a simultaneous clear.
      overflow     <= ovf_set_s | (overflow & ~clr_err);
      underflow    <= unf_set_s | (underflow & ~clr_err);
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word shown directly; last popped word held while empty.
    always_comb begin
      if (empty) begin
        data_out = dout_r;
      end else begin
        data_out = mem_r[rd_ptr_r];
      end
    end
  end else begin : g_reg
    // Registered read data, valid the cycle after an accepted read.
    always_comb begin
      data_out = dout_r;
    end
  end

endmodule
